// File: rtl/data_mem_bytelane.sv
// RV32 data memory with byte/halfword/word access, lane write enables and a zeroing sweep.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned H/W accesses raise err instead of aligning down.
module data_mem_bytelane #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] WD,
  input  logic              WE,
  input  logic [2:0]        funct3,
  input  logic              clr,
  output logic [DATA_W-1:0] RD,
  output logic              busy,
  output logic              err
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int DEPTH  = 2 ** WORD_W;

  // state | meaning
  // CLEAR | sweeping zeros into word cnt, accesses blocked
  // READY | normal load/store operation
  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [WORD_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        size;
  logic              illegal;
  logic              misaligned;
  logic              mis_err;
  logic              fault;
  logic [1:0]        off;
  logic [WORD_W-1:0] widx;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] rd_ext;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic              store_en;
  logic              sweep_en;

  assign size       = funct3[1:0];
  assign illegal    = (funct3 == 3'b011) | (funct3[2] & funct3[1]) | (WE & funct3[2]);
  assign misaligned = ((size == 2'b01) & A[0]) | ((size == 2'b10) & (A[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign off     = A[1:0];
  assign mis_err = misaligned;
`else
  // Without the trap, misaligned halfword/word accesses quietly snap to their natural boundary.
  assign off     = (size == 2'b01) ? {A[1], 1'b0} :
                   (size == 2'b10) ? 2'b00 : A[1:0];
  assign mis_err = 1'b0;
`endif

  assign fault   = illegal | mis_err;
  assign busy    = rst | (state == CLEAR);
  assign err     = ~busy & fault;
  assign widx    = A[ADDR_W-1:2];
  assign word    = mem[widx];
  assign shifted = word >> {off, 3'b000};

  always_comb begin
    rd_ext = '0;
    case (size)
      2'b00:   rd_ext = {{24{~funct3[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   rd_ext = {{16{~funct3[2] & shifted[15]}}, shifted[15:0]};
      default: rd_ext = shifted;
    endcase
  end

  assign RD = (busy | fault) ? '0 : rd_ext;

  always_comb begin
    be    = 4'hF;
    wdata = WD;
    case (size)
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{WD[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << off;
        wdata = {2{WD[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wdata = WD;
      end
    endcase
  end

  // clr in a READY cycle takes priority, so a coincident store is dropped.
  assign store_en = ~busy & WE & ~clr & ~fault;
  assign sweep_en = ~rst & (state == CLEAR);

  always_ff @(posedge clk) begin
    if (sweep_en) begin
      mem[cnt] <= '0;
    end else if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + WORD_W'(1);
          if (cnt == '1) state <= READY;
        end
        READY: begin
          if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Scoreboard bench for data_mem_bytelane: byte-array reference model, directed cases then random traffic.
module tb_data_mem_bytelane;

  logic        clk;
  logic        rst;
  logic [7:0]  A;
  logic [31:0] WD;
  logic        WE;
  logic [2:0]  funct3;
  logic        clr;
  logic [31:0] RD;
  logic        busy;
  logic        err;

  data_mem_bytelane #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .A(A), .WD(WD), .WE(WE), .funct3(funct3),
    .clr(clr), .RD(RD), .busy(busy), .err(err)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        busy;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_step = 0;

  logic [7:0] mem_m [256];
  int         busy_left = 0;

  function automatic bit is_err(input logic [2:0] f3, input logic we, input logic [7:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && f3[2]) return 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'd1 && a[0]) return 1'b1;
    if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_val(input logic [7:0] a, input logic [2:0] f3);
    int base;
    logic [31:0] v;
    v = 32'd0;
    case (f3[1:0])
      2'd0: begin
        v = {24'd0, mem_m[a]};
        if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        base = int'(a) & 'hFE;
        v = {16'd0, mem_m[base+1], mem_m[base]};
        if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      default: begin
        base = int'(a) & 'hFC;
        v = {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
      end
    endcase
    return v;
  endfunction

  task automatic zero_model();
    for (int i = 0; i < 256; i++) mem_m[i] = 8'd0;
    busy_left = 64;
  endtask

  task automatic model_edge();
    int base;
    if (rst) begin
      zero_model();
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (clr) begin
      zero_model();
    end else if (WE && !is_err(funct3, WE, A)) begin
      case (funct3[1:0])
        2'd0: mem_m[A] = WD[7:0];
        2'd1: begin
          base = int'(A) & 'hFE;
          mem_m[base]   = WD[7:0];
          mem_m[base+1] = WD[15:8];
        end
        default: begin
          base = int'(A) & 'hFC;
          for (int i = 0; i < 4; i++) mem_m[base+i] = WD[8*i +: 8];
        end
      endcase
    end
  endtask

  task automatic step(input logic r, input logic [7:0] a, input logic [31:0] wd,
                      input logic we, input logic [2:0] f3, input logic c);
    exp_t e;
    rst = r; A = a; WD = wd; WE = we; funct3 = f3; clr = c;
    e.busy = rst || (busy_left > 0);
    if (e.busy) begin
      e.err = 1'b0;
      e.rd  = 32'd0;
    end else begin
      e.err = is_err(f3, we, a);
      e.rd  = e.err ? 32'd0 : load_val(a, f3);
    end
    e.id = n_step;
    n_step++;
    q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 32'd0, 1'b0, 3'b010, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (busy !== e.busy) begin
        n_fail++;
        $display("FAIL busy step %0d: got %b want %b", e.id, busy, e.busy);
      end
      n_chk++;
      if (err !== e.err) begin
        n_fail++;
        $display("FAIL err step %0d A=%h f3=%0d: got %b want %b", e.id, A, funct3, err, e.err);
      end
      n_chk++;
      if (RD !== e.rd) begin
        n_fail++;
        $display("FAIL rd step %0d A=%h f3=%0d: got %h want %h", e.id, A, funct3, RD, e.rd);
      end
    end
  end

  initial begin
    logic [7:0] ra;
    logic [2:0] rf;
    int         rsel;
    // reset two cycles, sweep of 64, then every word reads zero
    step(1'b1, 8'h00, 32'd0, 1'b0, 3'b010, 1'b0);
    step(1'b1, 8'h00, 32'd0, 1'b0, 3'b010, 1'b0);
    idle(66);
    for (int w = 0; w < 64; w++) step(1'b0, 8'(w * 4), 32'd0, 1'b0, 3'b010, 1'b0);
    // word store then loads with sign and zero extension
    step(1'b0, 8'h10, 32'h8899AABB, 1'b1, 3'b010, 1'b0);
    step(1'b0, 8'h10, 32'd0, 1'b0, 3'b010, 1'b0);
    step(1'b0, 8'h13, 32'd0, 1'b0, 3'b000, 1'b0);
    step(1'b0, 8'h13, 32'd0, 1'b0, 3'b100, 1'b0);
    // byte and halfword lane stores
    step(1'b0, 8'h11, 32'h0000005A, 1'b1, 3'b000, 1'b0);
    step(1'b0, 8'h10, 32'd0, 1'b0, 3'b010, 1'b0);
    step(1'b0, 8'h12, 32'h00001234, 1'b1, 3'b001, 1'b0);
    step(1'b0, 8'h10, 32'd0, 1'b0, 3'b010, 1'b0);
    step(1'b0, 8'h12, 32'd0, 1'b0, 3'b001, 1'b0);
    step(1'b0, 8'h12, 32'd0, 1'b0, 3'b101, 1'b0);
    // misaligned word store
    step(1'b0, 8'h21, 32'hFFFFFFFF, 1'b1, 3'b010, 1'b0);
    step(1'b0, 8'h20, 32'd0, 1'b0, 3'b010, 1'b0);
    step(1'b0, 8'h23, 32'd0, 1'b0, 3'b001, 1'b0);
    // clr with coincident store drops the store
    step(1'b0, 8'h30, 32'd7, 1'b1, 3'b010, 1'b1);
    idle(65);
    step(1'b0, 8'h30, 32'd0, 1'b0, 3'b010, 1'b0);
    step(1'b0, 8'h10, 32'd0, 1'b0, 3'b010, 1'b0);
    // reset in mid-sweep restarts the full sweep; WE and clr ignored while busy
    step(1'b0, 8'h00, 32'd0, 1'b0, 3'b010, 1'b1);
    idle(20);
    step(1'b1, 8'h00, 32'd0, 1'b0, 3'b010, 1'b0);
    step(1'b0, 8'h04, 32'hDEADBEEF, 1'b1, 3'b010, 1'b1);
    idle(64);
    step(1'b0, 8'h04, 32'd0, 1'b0, 3'b010, 1'b0);
    // illegal funct3 on loads and stores
    step(1'b0, 8'h10, 32'd0, 1'b0, 3'b011, 1'b0);
    step(1'b0, 8'h10, 32'd0, 1'b0, 3'b110, 1'b0);
    step(1'b0, 8'h10, 32'h11111111, 1'b1, 3'b100, 1'b0);
    step(1'b0, 8'h10, 32'd0, 1'b0, 3'b010, 1'b0);
    // random traffic concentrated on a small window to hit recently stored data
    for (int i = 0; i < 3000; i++) begin
      ra   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom);
      rsel = $urandom_range(0, 9);
      rf   = (rsel < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom);
      if ($urandom_range(0, 1) == 1 && rsel < 8 && $urandom_range(0, 2) == 0) rf[2] = (rf != 3'b010);
      step(($urandom_range(0, 599) == 0), ra, $urandom, ($urandom_range(0, 1) == 1), rf,
           ($urandom_range(0, 199) == 0));
    end
    idle(2);
    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
